// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI block sequencer and its byte launcher.
package spi_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned POLL_W = 16;
    localparam int unsigned CRC_W  = 16;

    typedef enum logic [3:0] {
        SEQ_IDLE,
        SEQ_R_TOKEN,
        SEQ_R_DATA,
        SEQ_R_CRC,
        SEQ_W_TOKEN,
        SEQ_W_DATA,
        SEQ_W_CRC,
        SEQ_W_RESP,
        SEQ_W_BUSY,
        SEQ_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        LN_IDLE,
        LN_LAUNCH,
        LN_SETTLE,
        LN_WAIT
    } ln_state_e;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] ST_CARD_ERR = 2'd2;
    localparam logic [1:0] ST_ABORT    = 2'd3;

    localparam logic [BYTE_W-1:0] TOK_START   = 8'hFE;
    localparam logic [4:0]        RESP_ACCEPT = 5'b00101;
    localparam logic [BYTE_W-1:0] FILL        = 8'hFF;

endpackage

// File: rtl/spi_byte_launcher.sv
// Runs one shifter byte: start pulse, one settle cycle, wait for !sh_busy,
// then hands back the received byte with a one-cycle byte_done.
module spi_byte_launcher
    import spi_pkg::*;
(
    input  logic              clk7,
    input  logic              rst,
    input  logic              launch_c,
    input  logic              launch_write_c,
    input  logic [BYTE_W-1:0] launch_data_c,
    input  logic              sh_busy,
    input  logic [BYTE_W-1:0] sh_data_out,
    output logic              sh_start_read,
    output logic              sh_start_write,
    output logic [BYTE_W-1:0] sh_data_in,
    output logic              byte_done,
    output logic [BYTE_W-1:0] byte_data
);

    ln_state_e         lstate_q, lstate_d;
    logic              start_rd_q, start_rd_d;
    logic              start_wr_q, start_wr_d;
    logic [BYTE_W-1:0] data_in_q, data_in_d;
    logic              done_q, done_d;
    logic [BYTE_W-1:0] byte_q, byte_d;

    always_comb begin
        lstate_d   = lstate_q;
        start_rd_d = 1'b0;
        start_wr_d = 1'b0;
        data_in_d  = data_in_q;
        done_d     = 1'b0;
        byte_d     = byte_q;
        case (lstate_q)
            LN_IDLE: begin
                if (launch_c) begin
                    lstate_d   = LN_LAUNCH;
                    start_rd_d = !launch_write_c;
                    start_wr_d = launch_write_c;
                    data_in_d  = launch_data_c;
                end
            end
            LN_LAUNCH: lstate_d = LN_SETTLE;
            LN_SETTLE: lstate_d = LN_WAIT;
            LN_WAIT: begin
                if (!sh_busy) begin
                    lstate_d = LN_IDLE;
                    done_d   = 1'b1;
                    byte_d   = sh_data_out;
                end
            end
            default: lstate_d = LN_IDLE;
        endcase
    end

    always_ff @(posedge clk7 or posedge rst) begin
        if (rst) begin
            lstate_q   <= LN_IDLE;
            start_rd_q <= 1'b0;
            start_wr_q <= 1'b0;
            data_in_q  <= '0;
            done_q     <= 1'b0;
            byte_q     <= '0;
        end else begin
            lstate_q   <= lstate_d;
            start_rd_q <= start_rd_d;
            start_wr_q <= start_wr_d;
            data_in_q  <= data_in_d;
            done_q     <= done_d;
            byte_q     <= byte_d;
        end
    end

    assign sh_start_read  = start_rd_q;
    assign sh_start_write = start_wr_q;
    assign sh_data_in     = data_in_q;
    assign byte_done      = done_q;
    assign byte_data      = byte_q;

endmodule

// File: rtl/spi_block_sequencer.sv
// SD-card data-block sequencer: sequences token/payload/CRC/response/busy
// phases over the byte launcher so a whole block moves without CPU help.
module spi_block_sequencer
    import spi_pkg::*;
#(
    parameter int unsigned CNT_W         = 10,
    parameter int unsigned TOKEN_TIMEOUT = 4096,
    parameter int unsigned BUSY_TIMEOUT  = 65535
) (
    input  logic              clk7,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic              cmd_write,
    input  logic [CNT_W-1:0]  cmd_len,
    input  logic              cmd_abort,
    output logic              seq_busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [CRC_W-1:0]  crc_rx,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              sh_start_read,
    output logic              sh_start_write,
    output logic [BYTE_W-1:0] sh_data_in,
    input  logic [BYTE_W-1:0] sh_data_out,
    input  logic              sh_busy,
    output logic              sh_crc_reset,
    input  logic [CRC_W-1:0]  sh_crc_out
);

    localparam logic [POLL_W-1:0] TOK_LIMIT  = POLL_W'(TOKEN_TIMEOUT - 1);
    localparam logic [POLL_W-1:0] BUSY_LIMIT = POLL_W'(BUSY_TIMEOUT - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [POLL_W-1:0] poll_inc;
    logic              inflight_q, inflight_d;
    logic [1:0]        status_q, status_d;
    logic [CRC_W-1:0]  crc_rx_q, crc_rx_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic [BYTE_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_ready_q, done_q, busy_q, crc_reset_q, crc_reset_d;

    logic              byte_done;
    logic [BYTE_W-1:0] byte_data;
    logic              deliver_c, gate_c, launch_c, launch_write_c;
    logic [BYTE_W-1:0] launch_data_c;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        poll_d      = poll_q;
        status_d    = status_q;
        crc_rx_d    = crc_rx_q;
        crc_d       = crc_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q && !rd_ready;
        crc_reset_d = 1'b0;
        deliver_c   = 1'b0;
        poll_inc    = (poll_q == '1) ? poll_q : poll_q + POLL_W'(1);

        case (state_q)
            SEQ_IDLE: begin
                if (cmd_start) begin
                    state_d     = cmd_write ? SEQ_W_TOKEN : SEQ_R_TOKEN;
                    len_d       = cmd_len;
                    status_d    = ST_OK;
                    crc_reset_d = cmd_write;
                end
            end
            SEQ_DONE: state_d = SEQ_IDLE;
            default: begin
                // EVAL: byte_done marks the byte boundary, the only point abort is honoured
                if (byte_done && cmd_abort) begin
                    status_d = ST_ABORT;
                    state_d  = SEQ_DONE;
                end else if (byte_done) begin
                    case (state_q)
                        SEQ_R_TOKEN: begin
                            if (byte_data == TOK_START) begin
                                state_d = (len_q == '0) ? SEQ_R_CRC : SEQ_R_DATA;
                            end else if (byte_data == FILL) begin
                                if (poll_q == TOK_LIMIT) begin
                                    status_d = ST_TIMEOUT;
                                    state_d  = SEQ_DONE;
                                end else begin
                                    poll_d = poll_inc;
                                end
                            end else begin
                                status_d = ST_CARD_ERR;
                                state_d  = SEQ_DONE;
                            end
                        end
                        SEQ_R_DATA: begin
                            rd_data_d  = byte_data;
                            rd_valid_d = 1'b1;
                            deliver_c  = 1'b1;
                            idx_d      = idx_q + CNT_W'(1);
                            if (idx_q == len_q - CNT_W'(1)) state_d = SEQ_R_CRC;
                        end
                        SEQ_R_CRC: begin
                            if (idx_q == '0) begin
                                crc_rx_d[15:8] = byte_data;
                                idx_d          = CNT_W'(1);
                            end else begin
                                crc_rx_d[7:0] = byte_data;
                                status_d      = ST_OK;
                                state_d       = SEQ_DONE;
                            end
                        end
                        SEQ_W_TOKEN: begin
                            state_d = (len_q == '0) ? SEQ_W_CRC : SEQ_W_DATA;
                            crc_d   = sh_crc_out;
                        end
                        SEQ_W_DATA: begin
                            idx_d = idx_q + CNT_W'(1);
                            if (idx_q == len_q - CNT_W'(1)) begin
                                state_d = SEQ_W_CRC;
                                crc_d   = sh_crc_out;
                            end
                        end
                        SEQ_W_CRC: begin
                            if (idx_q == '0) idx_d = CNT_W'(1);
                            else             state_d = SEQ_W_RESP;
                        end
                        SEQ_W_RESP: begin
                            if (byte_data == FILL) begin
                                if (poll_q == TOK_LIMIT) begin
                                    status_d = ST_TIMEOUT;
                                    state_d  = SEQ_DONE;
                                end else begin
                                    poll_d = poll_inc;
                                end
                            end else if (byte_data[4:0] == RESP_ACCEPT) begin
                                state_d = SEQ_W_BUSY;
                            end else begin
                                status_d = ST_CARD_ERR;
                                state_d  = SEQ_DONE;
                            end
                        end
                        SEQ_W_BUSY: begin
                            if (byte_data == FILL) begin
                                status_d = ST_OK;
                                state_d  = SEQ_DONE;
                            end else if (poll_q == BUSY_LIMIT) begin
                                status_d = ST_TIMEOUT;
                                state_d  = SEQ_DONE;
                            end else begin
                                poll_d = poll_inc;
                            end
                        end
                        default: state_d = SEQ_IDLE;
                    endcase
                end
            end
        endcase

        if (state_d != state_q) begin
            poll_d = '0;
            idx_d  = '0;
        end
    end

    // Next byte is launched from the phase being entered, so EVAL can overlap the next launch.
    always_comb begin
        gate_c         = 1'b0;
        launch_write_c = 1'b0;
        launch_data_c  = FILL;
        case (state_d)
            SEQ_R_TOKEN, SEQ_R_CRC, SEQ_W_RESP, SEQ_W_BUSY: gate_c = 1'b1;
            SEQ_R_DATA: gate_c = (!rd_valid_q || rd_ready) && !deliver_c;
            SEQ_W_TOKEN: begin
                gate_c         = 1'b1;
                launch_write_c = 1'b1;
                launch_data_c  = TOK_START;
            end
            SEQ_W_DATA: begin
                gate_c         = wr_valid;
                launch_write_c = 1'b1;
                launch_data_c  = wr_data;
            end
            SEQ_W_CRC: begin
                gate_c         = 1'b1;
                launch_write_c = 1'b1;
                launch_data_c  = (idx_d == '0) ? crc_d[15:8] : crc_d[7:0];
            end
            default: gate_c = 1'b0;
        endcase
        launch_c   = gate_c && (state_q != SEQ_IDLE) && (state_q != SEQ_DONE)
                     && (!inflight_q || byte_done);
        inflight_d = launch_c ? 1'b1 : (byte_done ? 1'b0 : inflight_q);
    end

    always_ff @(posedge clk7 or posedge rst) begin
        if (rst) begin
            state_q     <= SEQ_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            poll_q      <= '0;
            inflight_q  <= 1'b0;
            status_q    <= ST_OK;
            crc_rx_q    <= '0;
            crc_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            wr_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            crc_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            poll_q      <= poll_d;
            inflight_q  <= inflight_d;
            status_q    <= status_d;
            crc_rx_q    <= crc_rx_d;
            crc_q       <= crc_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            wr_ready_q  <= launch_c && (state_d == SEQ_W_DATA);
            done_q      <= (state_d == SEQ_DONE);
            busy_q      <= (state_d != SEQ_IDLE);
            crc_reset_q <= crc_reset_d;
        end
    end

    spi_byte_launcher u_launcher (
        .clk7          (clk7),
        .rst           (rst),
        .launch_c      (launch_c),
        .launch_write_c(launch_write_c),
        .launch_data_c (launch_data_c),
        .sh_busy       (sh_busy),
        .sh_data_out   (sh_data_out),
        .sh_start_read (sh_start_read),
        .sh_start_write(sh_start_write),
        .sh_data_in    (sh_data_in),
        .byte_done     (byte_done),
        .byte_data     (byte_data)
    );

    assign seq_busy     = busy_q;
    assign done         = done_q;
    assign status       = status_q;
    assign crc_rx       = crc_rx_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign wr_ready     = wr_ready_q;
    assign sh_crc_reset = crc_reset_q;

endmodule

// File: tb/tb_spi_block_sequencer.sv
// Bench for spi_block_sequencer: behavioural shifter/card model plus
// scoreboards for the read stream and the MOSI byte sequence.
module tb_spi_block_sequencer;

    localparam int SH_LAT    = 2;
    localparam int WAIT_MAX  = 40000;

    logic        clk7 = 1'b0;
    logic        rst;
    logic        cmd_start, cmd_write, cmd_abort;
    logic [9:0]  cmd_len;
    logic        seq_busy, done;
    logic [1:0]  status;
    logic [15:0] crc_rx;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic [7:0]  wr_data  = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        sh_start_read, sh_start_write;
    logic [7:0]  sh_data_in;
    logic [7:0]  sh_data_out;
    logic        sh_busy;
    logic        sh_crc_reset;
    logic [15:0] sh_crc_out;

    spi_block_sequencer dut (
        .clk7(clk7), .rst(rst),
        .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
        .seq_busy(seq_busy), .done(done), .status(status), .crc_rx(crc_rx),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .sh_start_read(sh_start_read), .sh_start_write(sh_start_write), .sh_data_in(sh_data_in),
        .sh_data_out(sh_data_out), .sh_busy(sh_busy),
        .sh_crc_reset(sh_crc_reset), .sh_crc_out(sh_crc_out)
    );

    always #5 clk7 = ~clk7;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    logic [7:0] miso_q[$];
    logic [7:0] mosi_exp[$];
    logic [7:0] exp_rd[$];
    logic [7:0] wr_q[$];
    int launches = 0, wr_launches = 0;
    int rd_beats = 0, rd_valid_cycles = 0, crc_resets = 0;
    int stall_launches = 0;
    int stall_at = -1;
    bit stall_done = 1'b0;

    // Shifter + card model: busy rises the cycle after start, data valid when it falls
    initial begin
        int         lat;
        logic [7:0] pending;
        lat = 0;
        pending = 8'hFF;
        sh_busy = 1'b0;
        sh_data_out = 8'h00;
        forever begin
            @(posedge clk7 or posedge rst);
            if (rst) begin
                sh_busy     <= 1'b0;
                sh_data_out <= 8'h00;
                lat = 0;
            end else if (sh_start_read || sh_start_write) begin
                check_eq("launch_while_idle", 32'(sh_busy), 0);
                launches++;
                if (sh_start_write) begin
                    wr_launches++;
                    check_eq("mosi_expected", 32'(mosi_exp.size() != 0), 1);
                    if (mosi_exp.size() != 0) check_eq("mosi_byte", 32'(sh_data_in), 32'(mosi_exp.pop_front()));
                    pending = 8'hFF;
                end else begin
                    pending = (miso_q.size() != 0) ? miso_q.pop_front() : 8'hFF;
                end
                sh_busy <= 1'b1;
                lat = SH_LAT;
            end else if (sh_busy) begin
                if (lat == 0) begin
                    sh_busy     <= 1'b0;
                    sh_data_out <= pending;
                end else begin
                    lat--;
                end
            end
        end
    end

    // Read consumer, write producer and stall window, all moved on the falling edge
    initial begin
        int stall_left;
        stall_left = 0;
        forever begin
            @(negedge clk7);
            if (rd_valid) rd_valid_cycles++;
            if (sh_crc_reset) crc_resets++;
            if (!stall_done && rd_beats == stall_at && rd_valid) begin
                stall_left = 20;
                stall_done = 1'b1;
            end
            if (stall_left > 0) begin
                rd_ready = 1'b0;
                if (sh_start_read || sh_start_write) stall_launches++;
                stall_left--;
            end else begin
                rd_ready = 1'b1;
            end
            if (rd_valid && rd_ready) begin
                rd_beats++;
                check_eq("rd_expected", 32'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) check_eq("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
            end
            if (wr_valid && wr_ready && wr_q.size() != 0) void'(wr_q.pop_front());
            wr_valid = (wr_q.size() != 0);
            wr_data  = wr_valid ? wr_q[0] : 8'h00;
        end
    end

    task automatic start_cmd(input logic wr, input int len);
        @(negedge clk7);
        cmd_write = wr;
        cmd_len   = 10'(len);
        cmd_start = 1'b1;
        @(negedge clk7);
        cmd_start = 1'b0;
        check_eq("accept_busy", 32'(seq_busy), 1);
        check_eq("accept_no_launch", 32'(sh_start_read | sh_start_write), 0);
        @(negedge clk7);
        check_eq("first_launch", 32'(wr ? sh_start_write : sh_start_read), 1);
    endtask

    task automatic wait_done(input string tag, output logic [1:0] st);
        int n;
        n = 0;
        while (done !== 1'b1 && n < WAIT_MAX) begin
            @(negedge clk7);
            n++;
        end
        check_eq({tag, "_done"}, 32'(done), 1);
        st = status;
        @(negedge clk7);
        check_eq({tag, "_busy_drop"}, 32'(seq_busy), 0);
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({seq_busy, done, status, rd_valid, wr_ready, sh_start_read,
                    sh_start_write, sh_crc_reset, rd_data, sh_data_in});
    endfunction

    initial begin
        logic [1:0] st;
        logic [7:0] b;
        int l0, w0, r0, v0, c0, s0, n;

        rst = 1'b1;
        cmd_start = 1'b0;
        cmd_write = 1'b0;
        cmd_abort = 1'b0;
        cmd_len   = '0;
        sh_crc_out = 16'h0000;
        repeat (3) @(negedge clk7);
        check_eq("reset_outputs", out_vec(), 0);
        check_eq("reset_crc_rx", 32'(crc_rx), 0);
        rst = 1'b0;
        @(negedge clk7);

        // Read 512 bytes after two fill polls
        miso_q = {8'hFF, 8'hFF, 8'hFE};
        for (int i = 0; i < 512; i++) begin
            miso_q.push_back(8'(i));
            exp_rd.push_back(8'(i));
        end
        miso_q.push_back(8'h12);
        miso_q.push_back(8'h34);
        l0 = launches; r0 = rd_beats;
        start_cmd(1'b0, 512);
        wait_done("rd512", st);
        check_eq("rd512_status", 32'(st), 0);
        check_eq("rd512_crc", 32'(crc_rx), 32'h1234);
        check_eq("rd512_beats", 32'(rd_beats - r0), 512);
        check_eq("rd512_launches", 32'(launches - l0), 3 + 512 + 2);

        // Token never arrives
        miso_q.delete();
        l0 = launches; v0 = rd_valid_cycles;
        start_cmd(1'b0, 8);
        wait_done("rdto", st);
        check_eq("rdto_status", 32'(st), 1);
        check_eq("rdto_polls", 32'(launches - l0), 4096);
        check_eq("rdto_no_rd_valid", 32'(rd_valid_cycles - v0), 0);

        // Write 4 bytes, accepted, 10 busy polls
        sh_crc_out = 16'hBEEF;
        wr_q     = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        mosi_exp = {8'hFE, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hBE, 8'hEF};
        miso_q   = {8'hE5};
        repeat (10) miso_q.push_back(8'h00);
        miso_q.push_back(8'hFF);
        l0 = launches; w0 = wr_launches; c0 = crc_resets;
        start_cmd(1'b1, 4);
        wait_done("wr4", st);
        check_eq("wr4_status", 32'(st), 0);
        check_eq("wr4_mosi_left", 32'(mosi_exp.size()), 0);
        check_eq("wr4_wr_launches", 32'(wr_launches - w0), 7);
        check_eq("wr4_launches", 32'(launches - l0), 7 + 1 + 11);
        check_eq("wr4_crc_reset", 32'(crc_resets - c0), 1);
        check_eq("wr4_miso_left", 32'(miso_q.size()), 0);

        // Write rejected by the card
        sh_crc_out = 16'h1357;
        wr_q     = {8'h55};
        mosi_exp = {8'hFE, 8'h55, 8'h13, 8'h57};
        miso_q   = {8'h0B, 8'h00, 8'h00};
        l0 = launches;
        start_cmd(1'b1, 1);
        wait_done("wrerr", st);
        check_eq("wrerr_status", 32'(st), 2);
        check_eq("wrerr_launches", 32'(launches - l0), 5);
        check_eq("wrerr_no_busy_polls", 32'(miso_q.size()), 2);
        miso_q.delete();

        // Read with a 20-cycle consumer stall after 5 beats
        miso_q = {8'hFE};
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            miso_q.push_back(b);
            exp_rd.push_back(b);
        end
        miso_q.push_back(8'hAB);
        miso_q.push_back(8'hCD);
        r0 = rd_beats; s0 = stall_launches;
        stall_done = 1'b0;
        stall_at = rd_beats + 5;
        start_cmd(1'b0, 16);
        wait_done("rdstall", st);
        check_eq("rdstall_status", 32'(st), 0);
        check_eq("rdstall_crc", 32'(crc_rx), 32'hABCD);
        check_eq("rdstall_beats", 32'(rd_beats - r0), 16);
        check_eq("rdstall_hit", 32'(stall_done), 1);
        check_eq("rdstall_no_launch", 32'(stall_launches - s0), 0);
        check_eq("rdstall_exp_left", 32'(exp_rd.size()), 0);
        stall_at = -1;

        // Abort while data byte 2 (BB) is on the wire
        wr_q     = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        mosi_exp = {8'hFE, 8'hAA, 8'hBB};
        w0 = wr_launches;
        start_cmd(1'b1, 4);
        n = 0;
        while (wr_launches - w0 < 3 && n < 1000) begin
            @(negedge clk7);
            n++;
        end
        check_eq("abort_reached_byte2", 32'(wr_launches - w0), 3);
        cmd_abort = 1'b1;
        wait_done("abort", st);
        cmd_abort = 1'b0;
        check_eq("abort_status", 32'(st), 3);
        check_eq("abort_wr_launches", 32'(wr_launches - w0), 3);
        wr_q.delete();
        @(negedge clk7);

        // Async reset in the middle of a read
        miso_q = {8'hFE};
        for (int i = 0; i < 16; i++) begin
            miso_q.push_back(8'(i + 8'h40));
            exp_rd.push_back(8'(i + 8'h40));
        end
        r0 = rd_beats;
        start_cmd(1'b0, 16);
        n = 0;
        while (rd_beats - r0 < 3 && n < 1000) begin
            @(negedge clk7);
            n++;
        end
        check_eq("rst_mid_progress", 32'(rd_beats - r0 >= 3), 1);
        rst = 1'b1;
        @(negedge clk7);
        check_eq("rst_mid_outputs", out_vec(), 0);
        check_eq("rst_mid_crc_rx", 32'(crc_rx), 0);
        rst = 1'b0;
        miso_q.delete();
        exp_rd.delete();
        repeat (5) @(negedge clk7);
        check_eq("rst_mid_idle", 32'(seq_busy | sh_start_read | sh_start_write), 0);

        // Zero-length read still takes token and CRC
        miso_q = {8'hFE, 8'h56, 8'h78};
        l0 = launches; r0 = rd_beats;
        start_cmd(1'b0, 0);
        wait_done("rd0", st);
        check_eq("rd0_status", 32'(st), 0);
        check_eq("rd0_crc", 32'(crc_rx), 32'h5678);
        check_eq("rd0_launches", 32'(launches - l0), 3);
        check_eq("rd0_beats", 32'(rd_beats - r0), 0);

        repeat (3) @(negedge clk7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
